// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: default framing parameters and FSM state codes.
package uart_pkg;

    localparam int DATA_BITS_DEF    = 8;
    localparam int CLKS_PER_BIT_DEF = 868;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] PARITY    = 3'd3;
    localparam logic [2:0] STOP      = 3'd4;
    localparam logic [2:0] WAIT_HIGH = 3'd5;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for asynchronous pad inputs; resets to 1 so idle-high lines
// never show a false edge while the part comes out of reset.
module uart_rx_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver with mid-bit sampling and a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = uart_pkg::DATA_BITS_DEF
) (
    input  logic                 SYSCLK,
    input  logic                 SYSRESET,
    input  logic                 RX,
    input  logic                 enable,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err,
    output logic                 busy
);
    import uart_pkg::*;

    localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic [BAUD_W-1:0] HALF_LOAD = BAUD_W'(CLKS_PER_BIT / 2);
    localparam logic [BAUD_W-1:0] FULL_LOAD = BAUD_W'(CLKS_PER_BIT);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic                 rx_s;
    logic [2:0]           state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 baud_done;
    logic                 stop_sample;
    logic                 byte_ok;
    logic                 take;

    uart_rx_sync #(.WIDTH(1)) u_sync (
        .clk (SYSCLK),
        .rst (SYSRESET),
        .d   (RX),
        .q   (rx_s)
    );

    // The load value counts the cycle that loads it, so expiry is at 1, not 0.
    assign baud_done   = (baud_cnt == BAUD_W'(1));
    assign stop_sample = enable && (state == STOP) && baud_done;
    assign take        = rx_valid && rx_ready;
    assign busy        = (state != IDLE);

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic par_bad;

    assign par_bad = par_bit ^ (^shreg);
    assign byte_ok = stop_sample && rx_s && !par_bad;
`else
    assign byte_ok    = stop_sample && rx_s;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge SYSCLK) begin
        if (SYSRESET) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (!enable) begin
                state    <= IDLE;
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state    <= START;
                            bit_cnt  <= '0;
                            baud_cnt <= HALF_LOAD;
                        end
                    end
                    START: begin
                        if (baud_done) begin
                            if (rx_s) begin
                                state    <= IDLE;
                                baud_cnt <= '0;
                            end else begin
                                state    <= DATA;
                                baud_cnt <= FULL_LOAD;
                            end
                        end else begin
                            baud_cnt <= baud_cnt - 1'b1;
                        end
                    end
                    DATA: begin
                        if (baud_done) begin
                            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                            baud_cnt <= FULL_LOAD;
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                                state   <= PARITY;
`else
                                state   <= STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            baud_cnt <= baud_cnt - 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (baud_done) begin
                            par_bit  <= rx_s;
                            baud_cnt <= FULL_LOAD;
                            state    <= STOP;
                        end else begin
                            baud_cnt <= baud_cnt - 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (baud_done) begin
                            baud_cnt  <= '0;
                            frame_err <= !rx_s;
`ifdef UART_RX_PARITY_EN
                            parity_err <= par_bad;
`endif
                            // A low stop bit may be a break; wait for the line to recover.
                            state <= rx_s ? IDLE : WAIT_HIGH;
                        end else begin
                            baud_cnt <= baud_cnt - 1'b1;
                        end
                    end
                    WAIT_HIGH: begin
                        if (rx_s) state <= IDLE;
                    end
                    default: begin
                        state    <= IDLE;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                endcase
            end
        end
    end

    // Holding register: a completing byte replaces the old one only if it is being consumed.
    always_ff @(posedge SYSCLK) begin
        if (SYSRESET) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (byte_ok && (!rx_valid || take)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else begin
                if (take)    rx_valid <= 1'b0;
                if (byte_ok) overrun  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Randomized and directed bench for uart_rx_deserializer with CLKS_PER_BIT=16, 8N1.
module tb_uart_rx_deserializer;

    localparam int CPB = 16;
    localparam int DB  = 8;
    localparam int LAT = 2 + CPB / 2 + (DB + 1) * CPB + 1;

    logic          SYSCLK   = 1'b0;
    logic          SYSRESET = 1'b1;
    logic          RX       = 1'b1;
    logic          enable   = 1'b1;
    logic          rx_ready = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid, frame_err, overrun, parity_err, busy;

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, vcnt = 0;
    int fe_cyc = 0, ov_cyc = 0;
    int got_data[$];
    int got_cyc[$];
    int exp_data[$];
    int exp_fall[$];
    int f0, f1, fe_s, ov_s, vc_s, idle_at, seen_busy, exp_fe;

    uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .SYSCLK     (SYSCLK),
        .SYSRESET   (SYSRESET),
        .RX         (RX),
        .enable     (enable),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 SYSCLK = ~SYSCLK;
    always @(posedge SYSCLK) cyc <= cyc + 1;

    // Observation point: mid-cycle, well away from the active edge.
    always @(negedge SYSCLK) begin
        if (rx_valid && rx_ready) begin
            got_data.push_back(int'(rx_data));
            got_cyc.push_back(cyc);
        end
        if (rx_valid)   vcnt   <= vcnt + 1;
        if (parity_err) pe_cnt <= pe_cnt + 1;
        if (frame_err) begin
            fe_cnt <= fe_cnt + 1;
            fe_cyc <= cyc;
        end
        if (overrun) begin
            ov_cnt <= ov_cnt + 1;
            ov_cyc <= cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge SYSCLK);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Drives one frame LSB first; fall is the cycle in which the start edge appears at the pin.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int low_after,
                              output int fall);
        fall = cyc;
        RX = 1'b0;
        tick(CPB);
        for (int i = 0; i < DB; i++) begin
            RX = b[i];
            tick(CPB);
        end
        RX = stop;
        tick(CPB);
        if (low_after > 0) tick(low_after);
        RX = 1'b1;
    endtask

    // Pops the oldest consumed byte; fall < 0 skips the latency comparison.
    task automatic expect_byte(input string tag, input int exp_b, input int fall, input int lat);
        int d, c;
        chk({tag, "_present"}, int'(got_data.size() > 0), 1);
        if (got_data.size() > 0) begin
            d = got_data.pop_front();
            c = got_cyc.pop_front();
            chk({tag, "_data"}, d, exp_b);
            if (fall >= 0) chk({tag, "_lat"}, c - fall, lat);
        end
    endtask

    initial begin
        tick(3);
        chk("rst_data", int'(rx_data), 0);
        chk("rst_valid", int'(rx_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_flags", int'({frame_err, overrun, parity_err}), 0);
        SYSRESET = 1'b0;
        tick(5);

        // Clean byte with the consumer always ready.
        rx_ready = 1'b1;
        fe_s = fe_cnt; ov_s = ov_cnt; vc_s = vcnt;
        send_frame(8'hA5, 1'b1, 0, f0);
        tick(20);
        expect_byte("a5", 8'hA5, f0, LAT);
        chk("a5_valid_cycles", vcnt - vc_s, 1);
        chk("a5_flags", (fe_cnt - fe_s) + (ov_cnt - ov_s), 0);

        // Short low glitch must not start a frame.
        fe_s = fe_cnt; vc_s = vcnt;
        idle_at = -1; seen_busy = 0;
        RX = 1'b0;
        f0 = cyc;
        tick(4);
        RX = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (busy) seen_busy = 1;
            else if (seen_busy == 1 && idle_at < 0) idle_at = cyc - f0;
            tick(1);
        end
        chk("glitch_saw_busy", seen_busy, 1);
        chk("glitch_idle_by_11", int'(idle_at > 0 && idle_at <= 11), 1);
        chk("glitch_no_valid", vcnt - vc_s, 0);
        chk("glitch_no_ferr", fe_cnt - fe_s, 0);

        // Low stop bit followed by a held break, then a clean frame.
        fe_s = fe_cnt; vc_s = vcnt;
        send_frame(8'h3C, 1'b0, 40, f0);
        tick(10);
        chk("ferr_pulses", fe_cnt - fe_s, 1);
        chk("ferr_cycle", fe_cyc - f0, LAT);
        chk("ferr_no_valid", vcnt - vc_s, 0);
        send_frame(8'h5A, 1'b1, 0, f1);
        tick(10);
        expect_byte("5a", 8'h5A, f1, LAT);
        chk("ferr_single", fe_cnt - fe_s, 1);

        // Two frames while the consumer stalls: second one is dropped.
        rx_ready = 1'b0;
        ov_s = ov_cnt;
        send_frame(8'h11, 1'b1, 0, f0);
        send_frame(8'h22, 1'b1, 0, f1);
        tick(5);
        chk("ovr_pulses", ov_cnt - ov_s, 1);
        chk("ovr_cycle", ov_cyc - f1, LAT);
        chk("ovr_held_data", int'(rx_data), 8'h11);
        chk("ovr_held_valid", int'(rx_valid), 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        chk("ovr_valid_clear", int'(rx_valid), 0);
        expect_byte("ovr_rd", 8'h11, -1, 0);
        tick(20);
        chk("ovr_no_more", got_data.size(), 0);

        // Consumer accepts in the very cycle the next byte completes.
        ov_s = ov_cnt;
        send_frame(8'h33, 1'b1, 0, f0);
        tick(3);
        fork
            send_frame(8'h44, 1'b1, 0, f1);
            begin
                tick(LAT - 1);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
                chk("same_valid", int'(rx_valid), 1);
                chk("same_data", int'(rx_data), 8'h44);
            end
        join
        expect_byte("same_33", 8'h33, f1, LAT - 1);
        chk("same_no_ovr", ov_cnt - ov_s, 0);
        rx_ready = 1'b1;
        tick(1);
        expect_byte("same_44", 8'h44, -1, 0);

        // Reset pulse mid-frame clears a pending byte and the partial frame.
        rx_ready = 1'b0;
        send_frame(8'h77, 1'b1, 0, f0);
        tick(3);
        fork
            send_frame(8'hFF, 1'b1, 0, f0);
            begin
                tick(5 * CPB + 8);
                chk("rst_mid_busy_before", int'(busy), 1);
                SYSRESET = 1'b1;
                tick(1);
                SYSRESET = 1'b0;
                chk("rst_mid_busy", int'(busy), 0);
                chk("rst_mid_valid", int'(rx_valid), 0);
                chk("rst_mid_data", int'(rx_data), 0);
                chk("rst_mid_flags", int'({frame_err, overrun, parity_err}), 0);
            end
        join
        tick(10);
        rx_ready = 1'b1;
        tick(2);
        chk("rst_mid_nothing", got_data.size(), 0);
        send_frame(8'h81, 1'b1, 0, f1);
        tick(5);
        expect_byte("rst_81", 8'h81, f1, LAT);

        // Enable dropped for one cycle mid-frame; pending byte survives.
        rx_ready = 1'b0;
        fe_s = fe_cnt;
        send_frame(8'h66, 1'b1, 0, f0);
        tick(3);
        fork
            send_frame(8'hFF, 1'b1, 0, f0);
            begin
                tick(5 * CPB + 8);
                chk("en_busy_before", int'(busy), 1);
                enable = 1'b0;
                tick(1);
                enable = 1'b1;
                chk("en_busy", int'(busy), 0);
                chk("en_pending_valid", int'(rx_valid), 1);
                chk("en_pending_data", int'(rx_data), 8'h66);
            end
        join
        tick(10);
        chk("en_no_ferr", fe_cnt - fe_s, 0);
        rx_ready = 1'b1;
        tick(1);
        expect_byte("en_66", 8'h66, -1, 0);
        chk("en_nothing_else", got_data.size(), 0);
        send_frame(8'h81, 1'b1, 0, f1);
        tick(5);
        expect_byte("en_81", 8'h81, f1, LAT);

        // Random frames, some with a low stop bit and a trailing break.
        rx_ready = 1'b1;
        fe_s = fe_cnt;
        exp_fe = 0;
        for (int i = 0; i < 24; i++) begin
            logic [7:0] b;
            logic       bad;
            int         gap;
            b   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 3) == 0);
            gap = $urandom_range(1, 24);
            send_frame(b, !bad, bad ? $urandom_range(1, 30) : 0, f0);
            if (bad) begin
                exp_fe++;
                gap = gap + 4;
            end else begin
                exp_data.push_back(int'(b));
                exp_fall.push_back(f0);
            end
            tick(gap);
        end
        tick(20);
        chk("rnd_count", got_data.size(), exp_data.size());
        while (exp_data.size() > 0) begin
            int eb, ef;
            eb = exp_data.pop_front();
            ef = exp_fall.pop_front();
            expect_byte("rnd", eb, ef, LAT);
        end
        chk("rnd_ferr", fe_cnt - fe_s, exp_fe);
        chk("no_parity_err", pe_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- UART 8N1 receiver that consumes the SoC's serial TX line and recovers bytes for on-chip checking and loopback logging.
- Sits directly downstream of the SoC TX output.
- Provides a valid/ready byte interface with framing and overrun reporting.
- The line is sampled at mid-bit using a programmable clock divider.

Parameters:
- CLKS_PER_BIT, 868: SYSCLK cycles per bit (100 MHz / 115200). Legal range 4..65535.
- DATA_BITS, 8: payload bits per frame, LSB first.

Ports:
- SYSCLK  in  1  system clock; sole clock domain.
- SYSRESET  in  1  synchronous, active-high reset.
- RX  in  1  asynchronous serial line; idle high.
- enable  in  1  receiver enable; low = power-down.
- rx_data  out  DATA_BITS  received byte.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  consumer accepts rx_data.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: a completed byte was dropped.
- parity_err  out  1  one-cycle pulse; tied 0 unless the macro is defined.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, parity_err=0, busy=0. Synchronizer flops reset to 1. FSM=IDLE, counters=0.
- RX passes through a 2-FF synchronizer. The FSM sees line changes 2 cycles late.
- IDLE: a synchronized RX=0 while enable=1 -> START. Bit counter clears; baud counter loads CLKS_PER_BIT/2 (floor).
- START: at baud count expiry, sample RX.
  - RX=1 -> glitch; return to IDLE with no flags.
  - RX=0 -> DATA; reload baud counter with CLKS_PER_BIT.
- DATA: at each expiry, shift the sample into the MSB of the shift register (LSB-first line order). After DATA_BITS samples -> STOP (or PARITY when the macro is defined).
- STOP: at expiry, sample RX.
  - RX=1 -> byte complete; go to IDLE.
  - RX=0 -> pulse frame_err, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: hold until synchronized RX=1, then go to IDLE. This keeps a break condition from being read as repeated frames.
- Byte completion is the cycle of the stop-bit sample. Next cycle: rx_data loaded, rx_valid=1. Latency from the RX falling edge at the pin to rx_valid is 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles.
- Handshake: rx_valid holds with rx_data stable until a cycle with rx_valid & rx_ready. The next cycle has rx_valid=0, unless a byte completes in that same cycle.
- Completion with rx_valid=1 and rx_ready=0: pulse overrun. The new byte is dropped and the old byte is retained.
- Completion in the same cycle as rx_valid & rx_ready: the old byte is consumed, the new byte is loaded, rx_valid stays 1, and overrun stays 0.
- enable=0: FSM forced to IDLE and counters cleared on the next edge, aborting any frame in progress with no flags. The rx_data/rx_valid holding register is unaffected and the handshake still works.
- SYSRESET mid-frame: all state returns to reset values on the next edge. The partial frame is lost. Reception resumes at the next falling edge seen after reset deasserts.
- Baud counter width is $clog2(CLKS_PER_BIT+1). The counter never wraps; it reloads on expiry.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP that samples one even-parity bit. On mismatch: pulse parity_err at the stop-bit sample, discard the byte, return to IDLE (or WAIT_HIGH if the stop bit is also low; then both flags pulse). Frame length becomes DATA_BITS+3 bits and latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state, parity_err tied 0, 8N1 only.

Decomposition:
- Package uart_pkg:
  - state enum: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - DATA_BITS default constant.
  - CLKS_PER_BIT default constant.
- Sub-module uart_rx_sync: 2-FF synchronizer with reset value 1, reusable for the other asynchronous pad inputs (SDA, SPISDI).

Test Plan (CLKS_PER_BIT=16):
- Send 0xA5, 8N1, rx_ready=1 -> rx_data=0xA5 and rx_valid high exactly 155 cycles after RX falls, for 1 cycle. No flags.
- RX low for 4 cycles then high -> no rx_valid, no flags; busy returns to 0 within 11 cycles.
- Frame 0x3C with stop bit forced 0, RX held low 40 more cycles, then a clean frame 0x5A -> one frame_err pulse and no valid for 0x3C; 0x5A received correctly.
- Frames 0x11 then 0x22 back-to-back with rx_ready=0, then rx_ready=1 -> one overrun pulse at 0x22 completion; the consumer reads 0x11 only.
- rx_ready asserted in the same cycle 0x44 completes while 0x33 is pending -> 0x33 consumed, rx_data=0x44 next cycle, rx_valid stays 1, no overrun.
- SYSRESET pulsed for 1 cycle during bit 4 of 0xFF, then a clean frame 0x81 -> all outputs reset the following cycle; only 0x81 is delivered. Repeat with enable low for 1 cycle instead of reset: same result, and an already pending byte survives.
